// File: rtl/i2c_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : i2c_frame_ctrl
// Description : Write-only I2C frame sequencer in front of a byte-level I2C
//               master. A client request is turned into START, an address
//               byte, REQ_LEN payload bytes pulled from the client stream,
//               and STOP. A single DONE pulse reports the outcome on ERR.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   MAX_LEN         largest accepted payload length in bytes (1..15)
//   TIMEOUT_CYCLES  watchdog limit in clk cycles (used only with the macro)
// Optional feature
//   I2C_FRAME_TIMEOUT_EN  when defined, adds a per-state watchdog that ends a
//                         stuck frame with ERR=3
// Ports
//   clk, async_rst               clock, asynchronous active-high reset
//   req_valid/req_ready          frame request handshake
//   req_addr[6:0], req_len[3:0]  slave address and payload length
//   wr_data[7:0], wr_valid       payload byte stream from the client
//   wr_ready                     one-cycle pulse when a byte is consumed
//   done, err[1:0]               frame end pulse and status
//                                (0 ok, 1 addr NACK, 2 data NACK, 3 timeout)
//   m_start, m_addr, m_data,     controls toward the byte master
//   m_restart
//   m_busy, m_running,           status from the byte master
//   m_addr_sent
// ============================================================================
module i2c_frame_ctrl #(
  parameter int MAX_LEN        = 15,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       async_rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_addr,
  input  logic [3:0] req_len,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic       done,
  output logic [1:0] err,
  output logic       m_start,
  output logic [7:0] m_addr,
  output logic [7:0] m_data,
  output logic       m_restart,
  input  logic       m_busy,
  input  logic       m_running,
  input  logic       m_addr_sent
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ADDR  = 3'd2,
    S_LOAD  = 3'd3,
    S_BYTE  = 3'd4,
    S_STOP  = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  localparam logic [3:0] MAX_LEN_C = 4'(MAX_LEN);

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ANACK   = 2'd1;
  localparam logic [1:0] ERR_DNACK   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  state_t     state_q, state_d;
  logic [7:0] m_addr_q, m_addr_d;
  logic [7:0] m_data_q, m_data_d;
  logic [3:0] remaining_q, remaining_d;
  logic [1:0] err_q, err_d;
  logic       busy_seen_q, busy_seen_d;

  // Master status is registered once before use. This keeps the master's
  // output timing out of our next-state logic and gives the two-cycle
  // M_RUNNING-low to DONE latency.
  logic       busy_s_q, running_s_q, sent_s_q;

  logic       timeout_hit;

  // --------------------------------------------------------------------------
  // Optional watchdog
  // --------------------------------------------------------------------------
`ifdef I2C_FRAME_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // IDLE and LOAD are client-paced, so they never time out. STOP is not
  // watched either: after a timeout the frame only waits for the master.
  assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) &&
                       ((state_q == S_START) || (state_q == S_ADDR) ||
                        (state_q == S_BYTE));

  always_comb begin
    to_cnt_d = to_cnt_q;
    if ((state_d != state_q) || (state_q == S_IDLE) || (state_q == S_LOAD)) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_W'(TIMEOUT_CYCLES)) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    m_addr_d    = m_addr_q;
    m_data_d    = m_data_q;
    remaining_d = remaining_q;
    err_d       = err_q;
    busy_seen_d = busy_seen_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          err_d = ERR_OK;
          if ((req_len == 4'd0) || (req_len > MAX_LEN_C)) begin
            // Unusable length: report without touching the bus.
            err_d   = ERR_DNACK;
            state_d = S_FIN;
          end else begin
            m_addr_d    = {req_addr, 1'b0};
            remaining_d = req_len;
            state_d     = S_START;
          end
        end
      end

      S_START: begin
        if (timeout_hit) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_STOP;
        end else if (running_s_q) begin
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        if (timeout_hit) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_STOP;
        end else if (!running_s_q) begin
          // The master gave up; before the address was acknowledged this is
          // an address NACK, otherwise it can only be a data-side abort.
          err_d   = sent_s_q ? ERR_DNACK : ERR_ANACK;
          state_d = S_FIN;
        end else if (sent_s_q && !busy_s_q) begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        // SCL stays low here for as long as the client withholds data.
        if (wr_valid) begin
          m_data_d    = wr_data;
          remaining_d = remaining_q - 4'd1;
          busy_seen_d = 1'b0;
          state_d     = S_BYTE;
        end
      end

      S_BYTE: begin
        if (timeout_hit) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_STOP;
        end else if (!running_s_q) begin
          err_d   = ERR_DNACK;
          state_d = S_FIN;
        end else if (!busy_seen_q) begin
          if (busy_s_q) begin
            busy_seen_d = 1'b1;
          end
        end else if (!busy_s_q) begin
          busy_seen_d = 1'b0;
          state_d     = (remaining_q != 4'd0) ? S_LOAD : S_STOP;
        end
      end

      S_STOP: begin
        if (!running_s_q) begin
          state_d = S_FIN;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q     <= S_IDLE;
      m_addr_q    <= 8'd0;
      m_data_q    <= 8'd0;
      remaining_q <= 4'd0;
      err_q       <= 2'd0;
      busy_seen_q <= 1'b0;
      busy_s_q    <= 1'b0;
      running_s_q <= 1'b0;
      sent_s_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_addr_q    <= m_addr_d;
      m_data_q    <= m_data_d;
      remaining_q <= remaining_d;
      err_q       <= err_d;
      busy_seen_q <= busy_seen_d;
      busy_s_q    <= m_busy;
      running_s_q <= m_running;
      sent_s_q    <= m_addr_sent;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (decoded from state so reset takes effect without a clock)
  // --------------------------------------------------------------------------
  assign req_ready = (state_q == S_IDLE);
  assign wr_ready  = (state_q == S_LOAD) && wr_valid;
  assign done      = (state_q == S_FIN);
  assign err       = done ? err_q : 2'd0;
  assign m_start   = (state_q == S_START) || (state_q == S_ADDR) ||
                     (state_q == S_LOAD)  || (state_q == S_BYTE);
  assign m_addr    = m_addr_q;
  // The master samples the data byte in the consuming cycle, so the new
  // byte is passed straight through while WR_READY is high.
  assign m_data    = wr_ready ? wr_data : m_data_q;
  assign m_restart = 1'b0;

endmodule
`default_nettype wire
